// File: rtl/mem_req_arbiter_if.sv
// One request/response channel: requestor-side is master, responder-side is slave.
// valid/ready: a request transfers on a cycle where req_valid & req_ready; resp_valid is a one-cycle pulse with no backpressure.
interface mem_req_arbiter_if #(
    parameter int CPU_WIDTH      = 32,
    parameter int WORD_ADDR_BITS = 30
);
    logic                      req_valid;
    logic                      req_ready;
    logic [WORD_ADDR_BITS-1:0] req_addr;
    logic [CPU_WIDTH-1:0]      req_data;
    logic [3:0]                req_write;
    logic                      resp_valid;
    logic [CPU_WIDTH-1:0]      resp_data;

    modport master (
        output req_valid, req_addr, req_data, req_write,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_write,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin merge of instruction and data request streams onto one memory port,
// with an in-order tag FIFO steering each read response back to its issuer.
module mem_req_arbiter #(
    parameter int CPU_WIDTH       = 32,
    parameter int WORD_ADDR_BITS  = 30,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    mem_req_arbiter_if.slave                   i_bus,
    mem_req_arbiter_if.slave                   d_bus,
    mem_req_arbiter_if.master                  mem_bus,
    output logic                               resp_err,
    output logic                               dbg_last_grant,
    output logic [$clog2(MAX_OUTSTANDING):0]   dbg_count
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(MAX_OUTSTANDING);
    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

    logic                       last_grant;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [PTR_W:0]             count;
    logic [MAX_OUTSTANDING-1:0] tag_q;

    logic                 i_resp_valid_q;
    logic                 d_resp_valid_q;
    logic [CPU_WIDTH-1:0] i_resp_data_q;
    logic [CPU_WIDTH-1:0] d_resp_data_q;

    logic fifo_full, fifo_empty;
    logic i_elig, d_elig;
    logic grant_valid, grant_d;
    logic accept, push, pop, head_id;

    always_comb begin
        fifo_full  = (count == FULL_COUNT);
        fifo_empty = (count == '0);
        // Reads need a free tag slot; writes never produce a response so they bypass it.
        i_elig = i_bus.req_valid & ((|i_bus.req_write) | ~fifo_full);
        d_elig = d_bus.req_valid & ((|d_bus.req_write) | ~fifo_full);
        grant_valid = i_elig | d_elig;
        grant_d     = d_elig & (~i_elig | (last_grant == ID_I));
        accept  = grant_valid & mem_bus.req_ready;
        push    = accept & (mem_bus.req_write == 4'b0000);
        pop     = mem_bus.resp_valid & ~fifo_empty;
        head_id = tag_q[rd_ptr];
    end

    assign mem_bus.req_valid = grant_valid;
    assign mem_bus.req_addr  = grant_d ? d_bus.req_addr  : i_bus.req_addr;
    assign mem_bus.req_data  = grant_d ? d_bus.req_data  : i_bus.req_data;
    assign mem_bus.req_write = grant_d ? d_bus.req_write : i_bus.req_write;

    assign i_bus.req_ready  = accept & ~grant_d;
    assign d_bus.req_ready  = accept & grant_d;
    assign i_bus.resp_valid = i_resp_valid_q;
    assign d_bus.resp_valid = d_resp_valid_q;
    assign i_bus.resp_data  = i_resp_data_q;
    assign d_bus.resp_data  = d_resp_data_q;

    assign dbg_last_grant = last_grant;
    assign dbg_count      = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant     <= ID_D;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            tag_q          <= '0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
            i_resp_data_q  <= '0;
            d_resp_data_q  <= '0;
            resp_err       <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_d;
            end
            if (push) begin
                tag_q[wr_ptr] <= grant_d;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            i_resp_valid_q <= pop & (head_id == ID_I);
            d_resp_valid_q <= pop & (head_id == ID_D);
            if (pop & (head_id == ID_I)) begin
                i_resp_data_q <= mem_bus.resp_data;
            end
            if (pop & (head_id == ID_D)) begin
                d_resp_data_q <= mem_bus.resp_data;
            end
            // A response with nothing outstanding is dropped and latched as an error.
            if (mem_bus.resp_valid & fifo_empty) begin
                resp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_mem_req_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic resp_err;
    logic dbg_last_grant;
    logic [2:0] dbg_count;

    int n_checks = 0;
    int n_err    = 0;

    mem_req_arbiter_if #(.CPU_WIDTH(32), .WORD_ADDR_BITS(30)) i_if ();
    mem_req_arbiter_if #(.CPU_WIDTH(32), .WORD_ADDR_BITS(30)) d_if ();
    mem_req_arbiter_if #(.CPU_WIDTH(32), .WORD_ADDR_BITS(30)) m_if ();

    mem_req_arbiter #(.CPU_WIDTH(32), .WORD_ADDR_BITS(30), .MAX_OUTSTANDING(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_bus          (i_if.slave),
        .d_bus          (d_if.slave),
        .mem_bus        (m_if.master),
        .resp_err       (resp_err),
        .dbg_last_grant (dbg_last_grant),
        .dbg_count      (dbg_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_on = 1'b0;
    bit          m_last;
    bit          m_q[$];
    bit          m_err;
    bit          m_iv, m_dv;
    logic [31:0] m_id, m_dd;

    function automatic void predict(output bit gv, output bit gd);
        bit full, ie, de;
        full = (m_q.size() == DEPTH);
        ie = i_if.req_valid && (i_if.req_write != 4'b0 || !full);
        de = d_if.req_valid && (d_if.req_write != 4'b0 || !full);
        gv = ie || de;
        if (ie && de) gd = !m_last;
        else          gd = de;
    endfunction

    always @(posedge clk) begin : model_update
        bit gv, gd, id;
        if (reset) begin
            m_q.delete();
            m_last = 1'b1;
            m_err  = 1'b0;
            m_iv   = 1'b0;
            m_dv   = 1'b0;
            m_id   = '0;
            m_dd   = '0;
            m_on   = 1'b1;
        end else if (m_on) begin
            predict(gv, gd);
            m_iv = 1'b0;
            m_dv = 1'b0;
            if (m_if.resp_valid) begin
                if (m_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    id = m_q.pop_front();
                    if (id) begin m_dv = 1'b1; m_dd = m_if.resp_data; end
                    else    begin m_iv = 1'b1; m_id = m_if.resp_data; end
                end
            end
            if (gv && m_if.req_ready) begin
                m_last = gd;
                if ((gd ? d_if.req_write : i_if.req_write) == 4'b0) m_q.push_back(gd);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        bit gv, gd;
        if (m_on) begin
            predict(gv, gd);
            chk("mem_req_valid", 32'(m_if.req_valid), 32'(gv));
            chk("i_req_ready", 32'(i_if.req_ready), 32'(gv && !gd && m_if.req_ready));
            chk("d_req_ready", 32'(d_if.req_ready), 32'(gv && gd && m_if.req_ready));
            if (gv) begin
                chk("mem_req_addr", 32'(m_if.req_addr), gd ? 32'(d_if.req_addr) : 32'(i_if.req_addr));
                chk("mem_req_data", m_if.req_data, gd ? d_if.req_data : i_if.req_data);
                chk("mem_req_write", 32'(m_if.req_write), gd ? 32'(d_if.req_write) : 32'(i_if.req_write));
            end
            chk("i_resp_valid", 32'(i_if.resp_valid), 32'(m_iv));
            chk("d_resp_valid", 32'(d_if.resp_valid), 32'(m_dv));
            chk("i_resp_data", i_if.resp_data, m_id);
            chk("d_resp_data", d_if.resp_data, m_dd);
            chk("resp_err", 32'(resp_err), 32'(m_err));
            chk("count", 32'(dbg_count), 32'(m_q.size()));
            chk("last_grant", 32'(dbg_last_grant), 32'(m_last));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_i(input bit v, input logic [29:0] a, input logic [31:0] dat, input logic [3:0] w);
        i_if.req_valid = v; i_if.req_addr = a; i_if.req_data = dat; i_if.req_write = w;
    endtask

    task automatic set_d(input bit v, input logic [29:0] a, input logic [31:0] dat, input logic [3:0] w);
        d_if.req_valid = v; d_if.req_addr = a; d_if.req_data = dat; d_if.req_write = w;
    endtask

    task automatic set_mem(input bit rdy, input bit rv, input logic [31:0] rd);
        m_if.req_ready = rdy; m_if.resp_valid = rv; m_if.resp_data = rd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] mask);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = mask[b] ? new_w[b*8 +: 8] : old_w[b*8 +: 8];
        return r;
    endfunction

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1;
        set_i(0, '0, '0, '0);
        set_d(0, '0, '0, '0);
        set_mem(1, 0, '0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_count", 32'(dbg_count), 32'd0);
        chk("reset_last_grant", 32'(dbg_last_grant), 32'd1);
        chk("reset_err", 32'(resp_err), 32'd0);
        chk("reset_i_resp_data", i_if.resp_data, 32'h0);

        // Single I read.
        step();
        set_i(1, 30'h10, '0, 4'b0000);
        @(negedge clk);
        chk("t1_i_ready", 32'(i_if.req_ready), 32'd1);
        chk("t1_mem_addr", 32'(m_if.req_addr), 32'h10);
        step();
        set_i(0, '0, '0, '0);
        step();
        set_mem(1, 1, 32'hDEADBEEF);
        step();
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t1_i_resp_valid", 32'(i_if.resp_valid), 32'd1);
        chk("t1_i_resp_data", i_if.resp_data, 32'hDEADBEEF);
        chk("t1_d_resp_valid", 32'(d_if.resp_valid), 32'd0);
        step();
        @(negedge clk);
        chk("t1_i_resp_pulse", 32'(i_if.resp_valid), 32'd0);
        chk("t1_i_resp_hold", i_if.resp_data, 32'hDEADBEEF);
        step();

        // Contention: alternating grants and routed responses.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            set_i(k < 4, 30'h100, '0, 4'b0000);
            set_d(k < 4, 30'h200, '0, 4'b0000);
            set_mem(1, (k >= 1 && k <= 4), 32'hA0000000 + 32'(k) - 32'd1);
            @(negedge clk);
            if (k < 4) begin
                chk("t2_i_grant", 32'(i_if.req_ready), 32'((k % 2) == 0));
                chk("t2_d_grant", 32'(d_if.req_ready), 32'((k % 2) == 1));
            end
            if (k >= 2) begin
                if ((k % 2) == 0) begin
                    chk("t2_i_resp_valid", 32'(i_if.resp_valid), 32'd1);
                    chk("t2_i_resp_data", i_if.resp_data, 32'hA0000000 + 32'(k) - 32'd2);
                end else begin
                    chk("t2_d_resp_valid", 32'(d_if.resp_valid), 32'd1);
                    chk("t2_d_resp_data", d_if.resp_data, 32'hA0000000 + 32'(k) - 32'd2);
                end
            end
            step();
        end
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t2_err", 32'(resp_err), 32'd0);
        step();

        // Fill the tag FIFO, write past it, then free one slot.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            set_d(1, 30'h300 + 30'(k), '0, 4'b0000);
            @(negedge clk);
            chk("t3_d_ready", 32'(d_if.req_ready), 32'd1);
            step();
        end
        set_d(1, 30'h304, '0, 4'b0000);
        @(negedge clk);
        chk("t3_full_blocks", 32'(d_if.req_ready), 32'd0);
        chk("t3_full_count", 32'(dbg_count), 32'd4);
        #2 set_d(1, 30'h3F0, 32'hCAFEF00D, 4'b1111);
        #1 chk("t3_write_ready", 32'(d_if.req_ready), 32'd1);
        chk("t3_write_mask", 32'(m_if.req_write), 32'hF);
        step();
        set_d(1, 30'h304, '0, 4'b0000);
        set_mem(1, 1, 32'h50000000);
        @(negedge clk);
        chk("t3_full_with_pop", 32'(d_if.req_ready), 32'd0);
        step();
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t3_fifth_ready", 32'(d_if.req_ready), 32'd1);
        chk("t3_d_resp_data", d_if.resp_data, 32'h50000000);
        step();
        set_d(0, '0, '0, '0);
        for (int j = 0; j < 4; j++) begin
            set_mem(1, 1, 32'h50000001 + 32'(j));
            step();
        end
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t3_last_d_resp", d_if.resp_data, 32'h50000004);
        step();
        @(negedge clk);
        chk("t3_drained", 32'(dbg_count), 32'd0);
        step();

        // Partial write then read of the same word.
        set_d(1, 30'h40, 32'h0000ABCD, 4'b0011);
        @(negedge clk);
        chk("t4_w_ready", 32'(d_if.req_ready), 32'd1);
        chk("t4_w_data", m_if.req_data, 32'h0000ABCD);
        step();
        set_d(0, '0, '0, '0);
        set_i(1, 30'h40, '0, 4'b0000);
        @(negedge clk);
        chk("t4_write_no_push", 32'(dbg_count), 32'd0);
        chk("t4_r_ready", 32'(i_if.req_ready), 32'd1);
        step();
        set_i(0, '0, '0, '0);
        @(negedge clk);
        chk("t4_count_one", 32'(dbg_count), 32'd1);
        step();
        set_mem(1, 1, merge(32'h12345678, 32'h0000ABCD, 4'b0011));
        step();
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t4_merged", i_if.resp_data, 32'h1234ABCD);
        chk("t4_no_d_resp", 32'(d_if.resp_valid), 32'd0);
        step();

        // Memory stall with both requesting.
        do_reset();
        set_mem(0, 0, '0);
        set_i(1, 30'h500, '0, 4'b0000);
        set_d(1, 30'h600, '0, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_stall_i", 32'(i_if.req_ready), 32'd0);
            chk("t5_stall_d", 32'(d_if.req_ready), 32'd0);
            chk("t5_stall_last", 32'(dbg_last_grant), 32'd1);
            chk("t5_stall_count", 32'(dbg_count), 32'd0);
            step();
        end
        set_mem(1, 0, '0);
        @(negedge clk);
        chk("t5_i_first", 32'(i_if.req_ready), 32'd1);
        step();
        @(negedge clk);
        chk("t5_d_second", 32'(d_if.req_ready), 32'd1);
        step();
        set_i(0, '0, '0, '0);
        set_d(0, '0, '0, '0);
        @(negedge clk);
        chk("t5_in_flight", 32'(dbg_count), 32'd2);
        step();

        // Reset with reads in flight; late responses become errors.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_mem(1, 1, 32'h77770000 + 32'(k));
            step();
        end
        set_mem(1, 0, '0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t6_err_sticky", 32'(resp_err), 32'd1);
            chk("t6_no_i_resp", 32'(i_if.resp_valid), 32'd0);
            chk("t6_no_d_resp", 32'(d_if.resp_valid), 32'd0);
            step();
        end
        do_reset();
        @(negedge clk);
        chk("t6_err_cleared", 32'(resp_err), 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
